// File: rtl/sw_pkg.sv
// Shared constants and types for the switch-conditioning slice.
package sw_pkg;

  localparam int SW_WIDTH          = 8;
  localparam int SW_STABLE_DEFAULT = 16;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

endpackage : sw_pkg

// File: rtl/db_chan.sv
// One switch channel: two-flop synchroniser, mismatch counter, debounced
// output register and registered rise/fall strobes.
module db_chan
  import sw_pkg::*;
#(
  parameter int STABLE = SW_STABLE_DEFAULT,
  parameter int CW     = $clog2(STABLE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // A match clears the count even without tick, so short glitches never accumulate.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (!tick) begin
      cnt_d = cnt_q;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      out_d  = s2_q;
      cnt_d  = '0;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule : db_chan

// File: rtl/sw_debounce.sv
// Multi-channel switch conditioner: independent debounce per bit plus a
// combined any-change strobe built from the registered edge flags.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH  = SW_WIDTH,
  parameter int STABLE = SW_STABLE_DEFAULT,
  parameter int CW     = $clog2(STABLE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    db_chan #(
      .STABLE (STABLE),
      .CW     (CW)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .d    (sw_raw[i]),
      .q    (sw_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // Flags are already registered, so this stays aligned with sw_out.
  assign changed = |(rise | fall);

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce, checked every cycle against
// a behavioural model of the debounce rules.
module tb_sw_debounce;
  import sw_pkg::*;

  localparam int W  = SW_WIDTH;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: raw delayed two cycles, then each bit flips once it has disagreed
  // with the output for ST tick-qualified cycles in a row.
  logic [W-1:0] mDelay1, mDelay2, mOut, mRise, mFall;
  int           mRun [W];

  int riseSeen [W];
  int fallSeen [W];
  int changedSeen;

  sw_debounce #(
    .WIDTH  (W),
    .STABLE (ST)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .sw_raw  (sw_raw),
    .sw_out  (sw_out),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelStep(input logic [W-1:0] r, input logic t, input logic rs);
    if (rs) begin
      mDelay1 = '0; mDelay2 = '0; mOut = '0; mRise = '0; mFall = '0;
      for (int i = 0; i < W; i++) mRun[i] = 0;
    end else begin
      mRise = '0;
      mFall = '0;
      for (int i = 0; i < W; i++) begin
        if (mDelay2[i] == mOut[i]) mRun[i] = 0;
        else if (t) begin
          mRun[i] = mRun[i] + 1;
          if (mRun[i] == ST) begin
            mOut[i]  = mDelay2[i];
            mRise[i] = mDelay2[i];
            mFall[i] = ~mDelay2[i];
            mRun[i]  = 0;
          end
        end
      end
      mDelay2 = mDelay1;
      mDelay1 = r;
    end
  endtask

  task automatic clearSeen();
    for (int i = 0; i < W; i++) begin
      riseSeen[i] = 0;
      fallSeen[i] = 0;
    end
    changedSeen = 0;
  endtask

  task automatic applyStimulus(input string tag, input logic [W-1:0] r,
                               input logic t, input logic rs);
    sw_raw = r;
    tick   = t;
    rst    = rs;
    @(posedge clk);
    modelStep(r, t, rs);
    #1;
    checkOutput({tag, ".sw_out"}, 32'(sw_out), 32'(mOut));
    checkOutput({tag, ".rise"}, 32'(rise), 32'(mRise));
    checkOutput({tag, ".fall"}, 32'(fall), 32'(mFall));
    checkOutput({tag, ".changed"}, 32'(changed), 32'(|(mRise | mFall)));
    for (int i = 0; i < W; i++) begin
      riseSeen[i] += int'(rise[i]);
      fallSeen[i] += int'(fall[i]);
    end
    changedSeen += int'(changed);
  endtask

  // Holds inputs for limit edges; reports the 1-based edge of the first change.
  task automatic waitChange(input string tag, input logic [W-1:0] r,
                            input int limit, input int expIdx);
    int found;
    found = 0;
    for (int k = 1; k <= limit; k++) begin
      applyStimulus(tag, r, 1'b1, 1'b0);
      if (changed && found == 0) found = k;
    end
    checkOutput({tag, ".edge"}, 32'(found), 32'(expIdx));
  endtask

  initial begin
    int found;
    logic [W-1:0] r;
    logic t;
    sw_raw = '0; tick = 1'b1; rst = 1'b1;
    modelStep('0, 1'b1, 1'b1);

    // Reset held with all switches high, then release.
    clearSeen();
    for (int k = 0; k < 3; k++) applyStimulus("rst_hold", 8'hFF, 1'b1, 1'b1);
    checkOutput("rst_no_pulse", 32'(changedSeen), 32'd0);
    waitChange("rst_release", 8'hFF, 10, 6);
    checkOutput("rst_release_rise", 32'(riseSeen[0] + riseSeen[7]), 32'd2);

    // Clean single step from zero.
    for (int k = 0; k < 2; k++) applyStimulus("rst2", 8'h00, 1'b1, 1'b1);
    clearSeen();
    waitChange("step80", 8'h80, 10, 6);
    checkOutput("step80_rise7", 32'(riseSeen[7]), 32'd1);
    checkOutput("step80_out", 32'(sw_out), 32'h80);
    for (int k = 0; k < 10; k++) applyStimulus("back0", 8'h00, 1'b1, 1'b0);

    // Glitches one cycle short of and exactly at the window.
    clearSeen();
    for (int k = 0; k < 3; k++) applyStimulus("glitch3", 8'h08, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus("glitch3", 8'h00, 1'b1, 1'b0);
    checkOutput("glitch3_changed", 32'(changedSeen), 32'd0);
    clearSeen();
    for (int k = 0; k < 4; k++) applyStimulus("glitch4", 8'h08, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) applyStimulus("glitch4", 8'h00, 1'b1, 1'b0);
    checkOutput("glitch4_rise3", 32'(riseSeen[3]), 32'd1);
    checkOutput("glitch4_fall3", 32'(fallSeen[3]), 32'd1);

    // Bounce train on bit 0, then a steady high.
    clearSeen();
    for (int k = 0; k < 20; k++)
      applyStimulus("bounce", ((k % 4) < 2) ? 8'h01 : 8'h00, 1'b1, 1'b0);
    waitChange("bounce_hold", 8'h01, 10, 6);
    checkOutput("bounce_rise0", 32'(riseSeen[0]), 32'd1);
    for (int k = 0; k < 10; k++) applyStimulus("back0", 8'h00, 1'b1, 1'b0);

    // Tick every third cycle: flip on the fourth qualified mismatch edge.
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus("gated", 8'h20, (k % 3) == 0, 1'b0);
      if (changed && found == 0) found = k;
    end
    checkOutput("gated_edge", 32'(found), 32'd12);
    clearSeen();
    for (int k = 0; k < 12; k++) applyStimulus("tick_hold", 8'h00, 1'b0, 1'b0);
    checkOutput("tick_hold_changed", 32'(changedSeen), 32'd0);
    checkOutput("tick_hold_out", 32'(sw_out), 32'h20);
    for (int k = 0; k < 8; k++) applyStimulus("tick_resume", 8'h00, 1'b1, 1'b0);

    // Simultaneous rise and fall, then reset two edges into a new window.
    for (int k = 0; k < 10; k++) applyStimulus("pre0F", 8'h0F, 1'b1, 1'b0);
    clearSeen();
    waitChange("swapF0", 8'hF0, 10, 6);
    checkOutput("swap_changed", 32'(changedSeen), 32'd1);
    checkOutput("swap_rise7_fall0", 32'(riseSeen[7] + fallSeen[0]), 32'd2);
    for (int k = 0; k < 4; k++) applyStimulus("midcount", 8'h0F, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) applyStimulus("midrst", 8'h0F, 1'b1, 1'b1);
    checkOutput("midrst_out", 32'(sw_out), 32'h00);
    waitChange("midrst_release", 8'h0F, 10, 6);

    // Random traffic with sticky switch levels, gated ticks and rare resets.
    r = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      t = ($urandom_range(0, 3) != 0);
      applyStimulus("random", r, t, $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_sw_debounce

// File: doc/sw_debounce.md
# sw_debounce

Eight-channel switch conditioner that sits directly upstream of the priority encoder / seven-segment stage. It synchronises the raw board switches into the `clk` domain and debounces each bit independently. It presents a stable `WIDTH`-bit vector that drives the encoder's `in` input. It also emits per-bit edge strobes and an any-change strobe for downstream logic that reacts to switch activity.

## Interface
Parameters:
- `WIDTH`, 8: number of switch channels.
- `STABLE`, 16: consecutive counted cycles a synchronised input must differ from the current output before the output flips. Legal range is ≥ 2.
- `CW`, `$clog2(STABLE+1)`: counter width. Derived; do not override.

Ports:
- `clk` input, 1 bit: system clock. This block has one clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `tick` input, 1 bit: count enable. Tie to 1 for per-cycle debounce, or drive from a prescaler strobe.
- `sw_raw` input, `WIDTH` bits: asynchronous switch levels.
- `sw_out` output, `WIDTH` bits: debounced levels, fed to the encoder `in`.
- `rise` output, `WIDTH` bits: one-cycle pulse on the bit whose `sw_out` went 0→1.
- `fall` output, `WIDTH` bits: one-cycle pulse on the bit whose `sw_out` went 1→0.
- `changed` output, 1 bit: one-cycle pulse, the OR of `rise | fall`.

## Operation
Each channel is independent and has the following registers:
- Synchroniser: two flops, `s1 <= sw_raw[i]` and `s2 <= s1`.
- Mismatch counter: `cnt`, `CW` bits.
- Output register: `sw_out[i]`.

Each clock edge, the channel does the following, in priority order:
- **Reset.** If `rst`: `s1=s2=0`, `cnt=0`, `sw_out=0`, and `rise`, `fall`, `changed` are 0.
- **Match.** Else if `s2 == sw_out[i]`: `cnt <= 0`. This happens regardless of `tick`, so any glitch shorter than the window is discarded.
- **Mismatch, tick low.** Else if `tick == 0`: `cnt` holds.
- **Mismatch, window not reached.** Else if `cnt != STABLE-1`: `cnt <= cnt+1`.
- **Mismatch, window reached.** Else, when `cnt == STABLE-1` and `tick`:
  - `sw_out[i] <= s2` and `cnt <= 0`.
  - `rise[i]` or `fall[i]` is registered high for exactly the next cycle.

Further rules:
- `rise`, `fall` and `changed` are registered, so they are asserted in the same cycle that the new `sw_out` value is first visible.
- Several channels may flip on the same edge. Each gets its own `rise`/`fall` bit, and `changed` is a single pulse.
- Counter arithmetic is unsigned `CW`-bit. `cnt` never exceeds `STABLE-1`, so no wrap is possible.
- If `rst` is asserted mid-count, the count is abandoned. After `rst` is released, a switch that is held high takes the full synchroniser plus window latency again before `sw_out` rises. No edge pulse is produced during reset.

## Timing
- **Reset.** All outputs are 0 in the cycle after `rst` is sampled high.
- **Latency with `tick` tied high.** Suppose `sw_raw[i]` changes before edge E0 and then stays put.
  - `s1` takes the new value at E0 and `s2` at E1.
  - Mismatch is counted at edges E2 … E(1+STABLE).
  - `sw_out[i]` and the edge pulse update at edge E(1+STABLE). For `STABLE=16` this is E17.
- **Glitch rejection with `tick` tied high.** A `sw_raw` pulse seen by `s2` for fewer than `STABLE` cycles never changes `sw_out`.
- **Latency with `tick` gated.** The window counts `STABLE` tick-qualified cycles.
- **Maximum pulse rate.** Edge pulses on one channel are at most one per `STABLE` counted cycles.

## Structure
- Shared package `sw_pkg` holds:
  - `SW_WIDTH = 8`
  - `SW_STABLE_DEFAULT = 16`
  - the `sw_vec_t` typedef (`logic [SW_WIDTH-1:0]`)
- Sub-module `db_chan`: single-bit synchroniser, counter, output register and edge flags, with ports `clk`, `rst`, `tick`, `d`, `q`, `rise`, `fall`.
- `sw_debounce` instantiates `WIDTH` copies of `db_chan` in a generate loop and ORs the edge flags into `changed`.

## Test plan
All scenarios use `STABLE=4`.

1. **Reset values.** Assert `rst` for 3 cycles with `sw_raw=8'hFF` → `sw_out=0` and no pulses throughout. Release `rst` → `sw_out=8'hFF` appears 5 edges later (2 synchroniser + 4 window, one edge shared), with `rise=8'hFF` and `changed=1` for 1 cycle.
2. **Single clean step.** With `tick=1`, step `sw_raw` `8'h00→8'h80` → `sw_out=8'h80` at E5, `rise=8'h80` for one cycle, `fall=0`.
3. **Glitch.** Pulse `sw_raw[3]` high for 3 cycles → `sw_out` stays 0 and `changed` never fires. Repeat with a 4-cycle pulse → `sw_out[3]` rises and later falls, giving one `rise` and one `fall` pulse.
4. **Bounce train.** Toggle `sw_raw[0]` every 2 cycles for 20 cycles, then hold it at 1 → exactly one `rise[0]`, 5 edges after the final hold begins.
5. **Gated tick.** Run with `tick` high every 3rd cycle and apply a step on `sw_raw[5]` → the flip occurs on the 4th tick-qualified mismatch edge. Also hold `tick=0` during a mismatch → `cnt` freezes and `sw_out` does not change.
6. **Simultaneous edges and mid-count reset.**
   - Step `8'h0F→8'hF0` on one edge → `rise=8'hF0` and `fall=8'h0F` in the same cycle, with a single `changed` pulse.
   - Then assert `rst` 2 cycles into a new window → outputs clear, and the full latency applies afterwards.
